// File: rtl/fwft_fifo_drain.sv
// Two-entry drain stage for a first-word-fall-through FIFO: main/skid registers, pop decoded from registered state.
// Optional pop statistics counter enabled by defining FWFT_FIFO_DRAIN_STATS_EN.
module fwft_fifo_drain #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic             out_valid,
    output logic [width-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
`ifdef FWFT_FIFO_DRAIN_STATS_EN
    ,
    output logic [15:0]      pop_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [width-1:0]   main_q, main_d;
    logic [width-1:0]   skid_q, skid_d;
    logic               pop_s;
    logic               drain_s;
    logic               valid_s;

    // Pop and drain strobes; rst_n gates the pop so it drops immediately on reset assertion.
    always_comb begin
        valid_s = (state_q != ST_EMPTY);
        pop_s   = rst_n & ~fifo_empty & (state_q != ST_TWO) & ~flush;
        drain_s = valid_s & out_ready;
    end

    // Next-state and datapath selection.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (pop_s) begin
                        state_d = ST_ONE;
                        main_d  = fifo_dout;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (pop_s && !drain_s) begin
                        state_d = ST_TWO;
                        skid_d  = fifo_dout;
                    end else if (pop_s && drain_s) begin
                        state_d = ST_ONE;
                        main_d  = fifo_dout;
                    end else if (drain_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // The skid entry moves forward as the head leaves; no pop can happen here.
                    if (drain_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= {width{1'b0}};
            skid_q  <= {width{1'b0}};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign fifo_rd_en = pop_s;
    assign out_valid  = valid_s;
    assign out_data   = main_q;
    assign occupancy  = state_q;

`ifdef FWFT_FIFO_DRAIN_STATS_EN
    logic [15:0] pop_count_q, pop_count_d;

    // Free-running pop counter, wraps naturally and survives flush.
    always_comb begin
        if (pop_s) begin
            pop_count_d = pop_count_q + 16'd1;
        end else begin
            pop_count_d = pop_count_q;
        end
    end

    // Pop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_count_q <= 16'd0;
        end else begin
            pop_count_q <= pop_count_d;
        end
    end

    assign pop_count = pop_count_q;
`endif

endmodule

// File: tb/tb_fwft_fifo_drain.sv
// Directed bench for fwft_fifo_drain with a simple upstream FWFT FIFO model.
module tb_fwft_fifo_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  occupancy;
`ifdef FWFT_FIFO_DRAIN_STATS_EN
    logic [15:0] pop_count;
`endif

    logic [31:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    fwft_fifo_drain #(.width(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .occupancy  (occupancy)
`ifdef FWFT_FIFO_DRAIN_STATS_EN
        ,
        .pop_count  (pop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wr_ptr = 16;
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_data", out_data, 32'd0);
`ifdef FWFT_FIFO_DRAIN_STATS_EN
        chk("rst_pop_count", {16'd0, pop_count}, 32'd0);
`endif

        // Streaming 0x1..0x10 with out_ready held high.
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("stream_pre_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_pre_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_data", out_data, 32'(k));
        end
        chk("stream_last_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        chk("stream_end_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_end_occ", {30'd0, occupancy}, 32'd0);

        // Backpressure: 0xA,0xB,0xC with out_ready low.
        out_ready = 1'b0;
        mem[16] = 32'hA; mem[17] = 32'hB; mem[18] = 32'hC;
        wr_ptr = 19;
        tick();
        chk("bp_one_occ", {30'd0, occupancy}, 32'd1);
        chk("bp_one_data", out_data, 32'hA);
        tick();
        chk("bp_two_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_two_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("bp_two_data", out_data, 32'hA);
        tick();
        chk("bp_hold_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_hold_data", out_data, 32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_b", out_data, 32'hB);
        chk("bp_rel_b_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_rel_c", out_data, 32'hC);
        chk("bp_rel_c_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_end_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_end_ptr", 32'(rd_ptr), 32'd19);

        // Empty edge: single entry 0x55.
        mem[19] = 32'h55;
        wr_ptr = 20;
        tick();
        chk("edge_valid", {31'd0, out_valid}, 32'd1);
        chk("edge_data", out_data, 32'h55);
        chk("edge_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        chk("edge_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("edge_empty_occ", {30'd0, occupancy}, 32'd0);
        chk("edge_no_pop", 32'(rd_ptr), 32'd20);

        // Flush in TWO holding 0x3,0x4 with 0x5 still upstream.
        out_ready = 1'b0;
        mem[20] = 32'h3; mem[21] = 32'h4; mem[22] = 32'h5;
        wr_ptr = 23;
        tick();
        tick();
        chk("fl_two_occ", {30'd0, occupancy}, 32'd2);
        chk("fl_two_data", out_data, 32'h3);
        flush = 1'b1;
        #1;
        chk("fl_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_occ", {30'd0, occupancy}, 32'd0);
        chk("fl_empty_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("fl_no_pop", 32'(rd_ptr), 32'd22);
        flush = 1'b0;
        #1;
        chk("fl_resume_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        chk("fl_resume_data", out_data, 32'h5);
        out_ready = 1'b1;
        tick();
        chk("fl_resume_drain", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-cycle while in TWO.
        out_ready = 1'b0;
        mem[23] = 32'h7; mem[24] = 32'h8; mem[25] = 32'h9;
        wr_ptr = 26;
        tick();
        tick();
        chk("ar_two_occ", {30'd0, occupancy}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_occ", {30'd0, occupancy}, 32'd0);
        chk("ar_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("ar_data", out_data, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("ar_resume_data", out_data, 32'h9);
        chk("ar_resume_occ", {30'd0, occupancy}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("ar_resume_drain", {31'd0, out_valid}, 32'd0);

`ifdef FWFT_FIFO_DRAIN_STATS_EN
        chk("st_after_reset", {16'd0, pop_count}, 32'd1);
        out_ready = 1'b0;
        wr_ptr = rd_ptr + 2;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("st_flush_keep", {16'd0, pop_count}, 32'd3);
        out_ready = 1'b1;
        wr_ptr = rd_ptr + 65534;
        for (int c = 0; c < 70000; c++) begin
            if (rd_ptr == wr_ptr) break;
            tick();
        end
        chk("st_stream_done", 32'(rd_ptr), 32'(wr_ptr));
        chk("st_wrap", {16'd0, pop_count}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fwft_fifo_drain.md
FWFT_FIFO_DRAIN -- requirements
Module: fwft_fifo_drain

Interface
REQ-001 Parameter: width, default 32, bit width of one FIFO entry and of out_data.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 fifo_empty  input  1  empty flag from the upstream first-word-fall-through FIFO.
REQ-005 fifo_dout  input  width  head entry of the upstream FIFO, valid whenever fifo_empty=0.
REQ-006 fifo_rd_en  output  1  pop strobe to the upstream FIFO.
REQ-007 flush  input  1  synchronous discard of all buffered entries.
REQ-008 out_valid  output  1  downstream entry valid.
REQ-009 out_data  output  width  downstream entry.
REQ-010 out_ready  input  1  downstream accepts the entry when out_valid=1.
REQ-011 occupancy  output  2  number of entries held (0..2).
REQ-012 pop_count  output  16  total pops; present only with FWFT_FIFO_DRAIN_STATS_EN.

Function
REQ-013 Block SHALL hold two registers, main and skid; out_data SHALL always drive main.
REQ-014 State machine SHALL have states EMPTY (occupancy 0), ONE (1), TWO (2); out_valid=1 in ONE and TWO.
REQ-015 fifo_rd_en SHALL equal (~fifo_empty & state!=TWO & ~flush), decoded from registered state only, with no combinational path from out_ready.
REQ-016 pop = fifo_rd_en; drain = out_valid & out_ready.
REQ-017 EMPTY: pop -> ONE, main<=fifo_dout; else stay.
REQ-018 ONE: pop&~drain -> TWO, skid<=fifo_dout; pop&drain -> ONE, main<=fifo_dout; ~pop&drain -> EMPTY; else stay.
REQ-019 TWO: drain -> ONE, main<=skid; else stay (no pop possible).
REQ-020 Latency: an entry popped in cycle N SHALL appear with out_valid=1 in cycle N+1 when the block was EMPTY.
REQ-021 Throughput: with fifo_empty=0 and out_ready=1 continuously, one entry SHALL be delivered per cycle.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-023 Ordering: entries SHALL leave in exactly the order popped; none dropped or duplicated except by flush.
REQ-024 flush=1: next state EMPTY regardless of out_ready or fifo_empty; fifo_rd_en=0 that cycle; a drain coinciding with flush is still counted as delivered downstream.
REQ-025 fifo_empty=1 in any state SHALL suppress pop; fifo_dout SHALL then be ignored.
REQ-026 occupancy SHALL equal the state encoding (0,1,2) and never reach 3.

Reset
REQ-027 rst_n=0 SHALL immediately force state EMPTY, out_valid=0, occupancy=0, fifo_rd_en=0, main=0, skid=0, pop_count=0.
REQ-028 Reset asserted mid-transfer SHALL discard buffered entries; operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-029 Macro FWFT_FIFO_DRAIN_STATS_EN defined: pop_count port SHALL exist, increment by 1 on each pop, wrap 16'hFFFF -> 0, and not be cleared by flush.
REQ-030 Macro FWFT_FIFO_DRAIN_STATS_EN undefined: pop_count port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset: rst_n=0 asynchronously mid-cycle with state TWO -> out_valid=0, occupancy=0, fifo_rd_en=0 before next clk edge.
REQ-032 Streaming: FIFO preloaded 0x1..0x10, out_ready=1 -> out_data 0x1..0x10 on 16 consecutive cycles, first one cycle after first pop.
REQ-033 Backpressure: 0xA,0xB,0xC available, out_ready=0 -> occupancy 2, fifo_rd_en=0, out_data=0xA held; release out_ready -> 0xA,0xB,0xC in order.
REQ-034 Empty edge: single entry 0x55 then fifo_empty=1, out_ready=1 -> one valid cycle with 0x55, then EMPTY, no spurious pop.
REQ-035 Flush: state TWO holding 0x3,0x4, flush=1 with out_ready=0 -> next cycle out_valid=0, occupancy=0, no pop in flush cycle.
REQ-036 Stats (macro defined): 65537 pops -> pop_count=1; flush leaves pop_count unchanged.
